// File: rtl/wx_pkg.sv
// Shared types and constants for the sequential matrix-vector multiplier:
// default dimensions, FSM state encoding and the on-chip weight table.
package wx_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int N_OUT_DEF  = 4;
  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int ACC_W_DEF  = 48;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  // Default weights W[j][i] = j*N_IN + i + 1, i.e. 1..16 row-major.
  localparam logic signed [COEF_W_DEF-1:0] W_ROM [N_OUT_DEF][N_IN_DEF] = '{
    '{16'sd1,  16'sd2,  16'sd3,  16'sd4},
    '{16'sd5,  16'sd6,  16'sd7,  16'sd8},
    '{16'sd9,  16'sd10, 16'sd11, 16'sd12},
    '{16'sd13, 16'sd14, 16'sd15, 16'sd16}
  };

  // Same rule as W_ROM, for builds whose dimensions differ from the defaults.
  function automatic int w_default(input int row, input int col, input int n_in);
    return row * n_in + col + 1;
  endfunction

endpackage

// File: rtl/wx_mac.sv
// Time-shared signed multiply-accumulate: full-precision product,
// sign-extended into a wrapping ACC_W accumulator with clear and enable.
module wx_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_next
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise the tool infers a latch to hold the old value.
  always_comb begin
    prod     = a * b;
    acc_next = acc + ACC_W'(prod);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/wx_seq_matvec.sv
// y = W*x with one shared MAC: load N_IN samples, compute each row over
// N_IN cycles, then hold the row result on the master stream until taken.
module wx_seq_matvec
  import wx_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  input  logic                     axis_s_tvalid,
  output logic                     axis_s_tready,
  input  logic signed [DATA_W-1:0] axis_s_tdata,
  output logic                     axis_m_tvalid,
  input  logic                     axis_m_tready,
  output logic signed [ACC_W-1:0]  axis_m_tdata
);

  localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

  state_t                   state;
  logic [I_W-1:0]           i;
  logic [J_W-1:0]           j;
  logic signed [DATA_W-1:0] x_mem [N_IN];
  logic signed [COEF_W-1:0] coef;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     s_hs;
  logic                     m_hs;
  logic                     mac_clear;
  logic                     mac_en;

  assign axis_s_tready = (state == LOAD);
  assign s_hs          = axis_s_tready && axis_s_tvalid;
  assign m_hs          = axis_m_tvalid && axis_m_tready;
  // The accumulator starts clean for every row: after the last sample and
  // after each accepted result that is not the final row.
  assign mac_clear     = (s_hs && (i == I_LAST)) || (m_hs && (j != J_LAST));
  assign mac_en        = (state == COMPUTE);

  generate
    if (N_IN == N_IN_DEF && N_OUT == N_OUT_DEF) begin : g_rom
      always_comb coef = COEF_W'(W_ROM[j][i]);
    end else begin : g_formula
      always_comb coef = COEF_W'(w_default(int'(j), int'(i), N_IN));
    end
  endgenerate

  // NOTE: the sample buffer is deliberately not reset; it is always fully
  // rewritten before use, so a reset would only cost a wide reset fan-out.
  always_ff @(posedge in_clock) begin
    if (!in_reset && s_hs) begin
      x_mem[i] <= axis_s_tdata;
    end
  end

  wx_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (in_clock),
    .rst      (in_reset),
    .clear    (mac_clear),
    .en       (mac_en),
    .a        (x_mem[i]),
    .b        (coef),
    .acc_next (acc_next)
  );

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state         <= LOAD;
      i             <= '0;
      j             <= '0;
      axis_m_tvalid <= 1'b0;
      axis_m_tdata  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (s_hs) begin
            if (i == I_LAST) begin
              i     <= '0;
              j     <= '0;
              state <= COMPUTE;
            end else begin
              i <= i + I_W'(1);
            end
          end
        end
        COMPUTE: begin
          if (i == I_LAST) begin
            // The last product is folded in here so the result is ready
            // on the same edge the MAC would have stored it.
            axis_m_tdata  <= acc_next;
            axis_m_tvalid <= 1'b1;
            i             <= '0;
            state         <= OUTPUT;
          end else begin
            i <= i + I_W'(1);
          end
        end
        OUTPUT: begin
          if (axis_m_tready) begin
            axis_m_tvalid <= 1'b0;
            if (j != J_LAST) begin
              j     <= j + J_W'(1);
              state <= COMPUTE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_wx_seq_matvec.sv
// Table-driven and randomized bench for wx_seq_matvec against a plain
// dot-product reference using the default weights W[j][i] = j*N_IN+i+1.
module tb_wx_seq_matvec;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 48;
  localparam int N_VEC  = 8;
  localparam int BOUND  = 200;

  logic                     in_clock = 1'b0;
  logic                     in_reset;
  logic                     axis_s_tvalid;
  logic                     axis_s_tready;
  logic signed [DATA_W-1:0] axis_s_tdata;
  logic                     axis_m_tvalid;
  logic                     axis_m_tready;
  logic signed [ACC_W-1:0]  axis_m_tdata;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;

  typedef struct packed {
    logic [N_IN-1:0][DATA_W-1:0] x;
    logic                        gap;
    logic [7:0]                  bp;
    logic [N_OUT-1:0][ACC_W-1:0] y;
  } vec_t;

  vec_t tbl [N_VEC];

  wx_seq_matvec #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) dut (
    .in_clock      (in_clock),
    .in_reset      (in_reset),
    .axis_s_tvalid (axis_s_tvalid),
    .axis_s_tready (axis_s_tready),
    .axis_s_tdata  (axis_s_tdata),
    .axis_m_tvalid (axis_m_tvalid),
    .axis_m_tready (axis_m_tready),
    .axis_m_tdata  (axis_m_tdata)
  );

  always #5 in_clock = ~in_clock;
  always @(posedge in_clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: y[row] = sum_i (row*N_IN + i + 1) * x[i], wrapped to ACC_W.
  function automatic logic [ACC_W-1:0] model_y(input vec_t v, input int row);
    longint s = 0;
    for (int c = 0; c < N_IN; c++) begin
      s += longint'(row * N_IN + c + 1) * longint'($signed(v.x[c]));
    end
    return ACC_W'(s);
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input bit gap, input int bp);
    vec_t v;
    v      = '0;
    v.x[0] = DATA_W'(a);
    v.x[1] = DATA_W'(b);
    v.x[2] = DATA_W'(c);
    v.x[3] = DATA_W'(d);
    v.gap  = gap;
    v.bp   = 8'(bp);
    return v;
  endfunction

  task automatic set_y(input int k, input longint a, input longint b,
                       input longint c, input longint d);
    tbl[k].y[0] = ACC_W'(a);
    tbl[k].y[1] = ACC_W'(b);
    tbl[k].y[2] = ACC_W'(c);
    tbl[k].y[3] = ACC_W'(d);
  endtask

  // Starts and ends just after a falling edge; t_last is the edge of the
  // final input handshake.
  task automatic send_vec(input vec_t v, output longint t_last);
    int n;
    t_last = 0;
    for (int k = 0; k < N_IN; k++) begin
      if (v.gap) begin
        axis_s_tvalid = 1'b0;
        axis_s_tdata  = DATA_W'($urandom);
        @(negedge in_clock);
      end
      axis_s_tvalid = 1'b1;
      axis_s_tdata  = $signed(v.x[k]);
      n = 0;
      while (!axis_s_tready && n < BOUND) begin
        @(negedge in_clock);
        n++;
      end
      if (!axis_s_tready) begin
        check("s_tready_timeout", 0, 1);
        axis_s_tvalid = 1'b0;
        return;
      end
      @(negedge in_clock);
      t_last = cyc;
    end
    axis_s_tvalid = 1'b0;
    axis_s_tdata  = DATA_W'($urandom);
  endtask

  task automatic collect(input vec_t v, input longint t_last);
    int     n;
    longint t_ref;
    longint t_prev;
    longint held;
    t_ref  = t_last;
    t_prev = 0;
    for (int r = 0; r < N_OUT; r++) begin
      n = 0;
      // Inputs offered while busy must be ignored.
      while (!axis_m_tvalid && n < BOUND) begin
        axis_s_tvalid = 1'($urandom);
        axis_s_tdata  = DATA_W'($urandom);
        @(negedge in_clock);
        n++;
        if (!axis_m_tvalid && n == 2) check("s_tready_busy", axis_s_tready, 0);
      end
      axis_s_tvalid = 1'b0;
      if (!axis_m_tvalid) begin
        check($sformatf("m_tvalid_timeout_row%0d", r), 0, 1);
        return;
      end
      check($sformatf("latency_row%0d", r), cyc - t_ref, N_IN);
      if (r > 0 && v.bp == 0) check($sformatf("spacing_row%0d", r), cyc - t_prev, N_IN + 1);
      t_prev = cyc;
      held   = axis_m_tdata;
      for (int b = 0; b < int'(v.bp); b++) begin
        @(negedge in_clock);
        check($sformatf("stall_valid_row%0d", r), axis_m_tvalid, 1);
        check($sformatf("stall_data_row%0d", r), axis_m_tdata, held);
      end
      check($sformatf("y_row%0d", r), axis_m_tdata, longint'($signed(v.y[r])));
      axis_m_tready = 1'b1;
      @(negedge in_clock);
      axis_m_tready = 1'b0;
      t_ref = cyc;
      check($sformatf("no_dup_row%0d", r), axis_m_tvalid, 0);
    end
    check("s_tready_after_vec", axis_s_tready, 1);
  endtask

  initial begin
    longint t_last;
    vec_t   v;
    int     n;

    tbl[0] = mk(1, 2, 3, 4, 1'b0, 0);
    set_y(0, 30, 70, 110, 150);
    tbl[1] = mk(-32768, -32768, -32768, -32768, 1'b0, 0);
    set_y(1, -327680, -851968, -1376256, -1900544);
    tbl[2] = mk(1, 2, 3, 4, 1'b0, 5);
    set_y(2, 30, 70, 110, 150);
    tbl[3] = mk(1, 2, 3, 4, 1'b1, 0);
    set_y(3, 30, 70, 110, 150);
    for (int k = 4; k < N_VEC; k++) begin
      tbl[k] = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)));
      for (int r = 0; r < N_OUT; r++) tbl[k].y[r] = model_y(tbl[k], r);
    end

    in_reset      = 1'b1;
    axis_s_tvalid = 1'b0;
    axis_s_tdata  = '0;
    axis_m_tready = 1'b0;
    repeat (3) @(negedge in_clock);
    check("reset_m_tvalid", axis_m_tvalid, 0);
    check("reset_m_tdata", axis_m_tdata, 0);
    check("reset_s_tready", axis_s_tready, 1);
    in_reset = 1'b0;
    @(negedge in_clock);

    for (int k = 0; k < N_VEC; k++) begin
      send_vec(tbl[k], t_last);
      collect(tbl[k], t_last);
    end

    // Reset during the second row's computation discards the vector.
    v = mk(1, 2, 3, 4, 1'b0, 0);
    send_vec(v, t_last);
    n = 0;
    while (!axis_m_tvalid && n < BOUND) begin
      @(negedge in_clock);
      n++;
    end
    check("midrun_row0_valid", axis_m_tvalid, 1);
    check("midrun_row0_data", axis_m_tdata, 30);
    axis_m_tready = 1'b1;
    @(negedge in_clock);
    axis_m_tready = 1'b0;
    @(negedge in_clock);
    in_reset = 1'b1;
    @(negedge in_clock);
    in_reset = 1'b0;
    check("midrun_reset_m_tvalid", axis_m_tvalid, 0);
    check("midrun_reset_s_tready", axis_s_tready, 1);
    check("midrun_reset_m_tdata", axis_m_tdata, 0);
    repeat (N_IN + 2) @(negedge in_clock);
    check("midrun_no_stale", axis_m_tvalid, 0);

    v = mk(0, 0, 0, 1, 1'b0, 0);
    v.y[0] = ACC_W'(4);
    v.y[1] = ACC_W'(8);
    v.y[2] = ACC_W'(12);
    v.y[3] = ACC_W'(16);
    send_vec(v, t_last);
    collect(v, t_last);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
